// File: rtl/shift_exec_unit_pkg.sv
// ============================================================================
//  Module      : shift_exec_unit_pkg
//  Description : Shared opcodes, FSM states and constants for the multi-pass
//                shift/rotate execute unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package shift_exec_unit_pkg;

  // Decode opcodes (5..7 are reserved and execute as a pass-through)
  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRA = 3'd1;
  localparam logic [2:0] OP_SRL = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PASS_A = 3'd1,
    ST_PASS_B = 3'd2,
    ST_PASS_C = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // Barrel shifter direction select
  localparam logic DIR_LEFT        = 1'b0;
  localparam logic DIR_ARITH_RIGHT = 1'b1;

  // (32 - m) evaluated in 6 bits and truncated; for m = 0 this yields 0,
  // which is also (32 - 0) mod 32, so it doubles as the ROR amount remap.
  function automatic logic [4:0] comp_amount(input logic [4:0] m);
    return 5'(6'd32 - {1'b0, m});
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_exec_unit_barrelshift.sv
// ============================================================================
//  Module      : barrelshift
//  Description : Combinational 32-bit barrel shifter. dir = 0 shifts left
//                logically, dir = 1 shifts right arithmetically.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module barrelshift (
  input  logic [31:0] operand,
  input  logic [4:0]  amount,
  input  logic        dir,
  output logic [31:0] result
);

  // Single shifter; direction selects between the two native shift kinds
  always_comb begin
    if (dir) begin
      result = $unsigned($signed(operand) >>> amount);
    end else begin
      result = operand << amount;
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_exec_unit.sv
// ============================================================================
//  Module      : shift_exec_unit
//  Description : Execute-stage shift/rotate unit. Builds SRL, ROL and ROR out
//                of 1-3 passes through one shared left/arith-right shifter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_exec_unit
  import shift_exec_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  state_e             state_q,     state_d;
  logic [2:0]         op_q,        op_d;        // executed op: SLL/SRA/SRL/ROL
  logic [WIDTH-1:0]   x_q,         x_d;
  logic [SHAMT_W-1:0] m_q,         m_d;
  logic [WIDTH-1:0]   l_q,         l_d;         // ROL left part
  logic [WIDTH-1:0]   r_q,         r_d;         // right-shifted part
  logic [WIDTH-1:0]   out_data_q,  out_data_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH-1:0]   sh_operand;
  logic [SHAMT_W-1:0] sh_amount;
  logic               sh_dir;
  logic [WIDTH-1:0]   sh_result;
  logic [SHAMT_W-1:0] m_comp;
  logic               accept;

  assign in_ready  = (state_q == ST_IDLE) && reset_n;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign m_comp    = comp_amount(m_q);

  barrelshift u_barrelshift (
    .operand (sh_operand),
    .amount  (sh_amount),
    .dir     (sh_dir),
    .result  (sh_result)
  );

  // Route the shared shifter's inputs according to the current pass
  always_comb begin
    sh_operand = x_q;
    sh_amount  = m_q;
    sh_dir     = DIR_LEFT;
    case (state_q)
      ST_PASS_A: begin
        sh_dir = ((op_q == OP_SRA) || (op_q == OP_SRL)) ? DIR_ARITH_RIGHT : DIR_LEFT;
      end
      ST_PASS_B: begin
        sh_amount = m_comp;
        if (op_q == OP_SRL) begin
          // Mask of the top m bits that sign extension may have polluted
          sh_operand = ALL_ONES;
        end else begin
          // ROL: bits wrapping around from the top
          sh_dir = DIR_ARITH_RIGHT;
        end
      end
      ST_PASS_C: begin
        // Mask of the upper 32-m bits, cleared out of the arith-right part
        sh_operand = ALL_ONES;
      end
      default: ;
    endcase
  end

  // Next-state, operand capture, pass register and result combine logic
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    x_d         = x_q;
    m_d         = m_q;
    l_d         = l_q;
    r_d         = r_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          x_d     = in_data;
          state_d = ST_PASS_A;
          if ((in_op > OP_ROR) || (in_shamt == '0)) begin
            op_d = OP_SLL;
            m_d  = '0;
          end else if (in_op == OP_ROR) begin
            op_d = OP_ROL;
            m_d  = comp_amount(in_shamt);
          end else begin
            op_d = in_op;
            m_d  = in_shamt;
          end
        end
      end
      ST_PASS_A: begin
        if (op_q == OP_SRL) begin
          r_d     = sh_result;
          state_d = ST_PASS_B;
        end else if (op_q == OP_ROL) begin
          l_d     = sh_result;
          state_d = ST_PASS_B;
        end else begin
          out_data_d  = sh_result;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_PASS_B: begin
        if (op_q == OP_SRL) begin
          out_data_d  = r_q & ~sh_result;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          r_d     = sh_result;
          state_d = ST_PASS_C;
        end
      end
      ST_PASS_C: begin
        out_data_d  = l_q | (r_q & ~sh_result);
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_data_d  = '0;
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_data_d  = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low clear
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_SLL;
      x_q         <= '0;
      m_q         <= '0;
      l_q         <= '0;
      r_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      x_q         <= x_d;
      m_q         <= m_d;
      l_q         <= l_d;
      r_q         <= r_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_exec_unit.sv
// ============================================================================
//  Module      : tb_shift_exec_unit
//  Description : Directed self-checking bench for shift_exec_unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shift_exec_unit;
  import shift_exec_unit_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cyc;
  int prev_acc;
  int prev_k;

  shift_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference for the architectural result
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] x,
                                            input logic [4:0] n);
    logic [31:0] r;
    int          sh;
    sh = n;
    case (op)
      3'd0:    r = x << sh;
      3'd1:    r = $unsigned($signed(x) >>> sh);
      3'd2:    r = x >> sh;
      3'd3:    r = (sh == 0) ? x : ((x << sh) | (x >> (32 - sh)));
      3'd4:    r = (sh == 0) ? x : ((x >> sh) | (x << (32 - sh)));
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic int passes(input logic [2:0] op, input logic [4:0] n);
    if (n == 0 || op > 3'd4) return 1;
    if (op == 3'd2) return 2;
    if (op == 3'd3 || op == 3'd4) return 3;
    return 1;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] x,
                       input logic [4:0] n);
    int w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = x;
    in_shamt = n;
    @(posedge clock);
    @(negedge clock);
    acc_cyc  = cyc;
    // Scramble the request lines: the in-flight op must not see them
    in_valid = 1'b0;
    in_op    = ~op;
    in_data  = ~x;
    in_shamt = ~n;
  endtask

  task automatic wait_result(input string tag, input int k, input logic [31:0] exp);
    int lat = 0;
    while (!out_valid && lat < 12) begin
      @(posedge clock);
      @(negedge clock);
      lat++;
    end
    chk({tag, "_latency"}, lat, k);
    chk({tag, "_data"}, out_data, exp);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                        input logic [4:0] n, input logic [31:0] exp, input int k);
    issue(tag, op, x, n);
    wait_result(tag, k, exp);
  endtask

  logic [2:0]  b_op [8];
  logic [31:0] b_x  [8];
  logic [4:0]  b_n  [8];

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_data   = 32'd0;
    in_shamt  = 5'd0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_in_ready_after", {31'd0, in_ready}, 32'd1);

    // Directed vectors
    run_op("rol1",    OP_ROL, 32'h8000_0001, 5'd1,  32'h0000_0003, 3);
    run_op("srl4",    OP_SRL, 32'h8000_0000, 5'd4,  32'h0800_0000, 2);
    run_op("sra4",    OP_SRA, 32'h8000_0000, 5'd4,  32'hF800_0000, 1);
    run_op("sra31",   OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1);
    run_op("ror8",    OP_ROR, 32'h1234_5678, 5'd8,  32'h7812_3456, 3);
    run_op("ror0",    OP_ROR, 32'h1234_5678, 5'd0,  32'h1234_5678, 1);
    run_op("rsvd7",   3'd7,   32'h1234_5678, 5'd5,  32'h1234_5678, 1);

    // Backpressure: result held, competing request ignored
    @(negedge clock);
    out_ready = 1'b0;
    run_op("bp_sll", OP_SLL, 32'h0000_0001, 5'd4, 32'h0000_0010, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_op    = OP_SRA;
      in_data  = 32'hFFFF_0000;
      in_shamt = 5'd3;
      @(posedge clock);
      @(negedge clock);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_data", out_data, 32'h0000_0010);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("bp_xfer_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_xfer_data", out_data, 32'd0);
    chk("bp_xfer_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset during PASS_B of a rotate
    issue("abort_rol", OP_ROL, 32'h8000_0001, 5'd1);
    @(posedge clock);
    @(negedge clock);
    chk("abort_in_pass_b", {29'd0, dut.state_q}, {29'd0, ST_PASS_B});
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_out_data", out_data, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_state", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
    reset_n = 1'b1;
    @(negedge clock);
    run_op("post_rst_sll", OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1);

    // Back-to-back mixed ops, consumer always ready
    b_op[0] = OP_SLL; b_x[0] = 32'hDEAD_BEEF; b_n[0] = 5'd3;
    b_op[1] = OP_SRA; b_x[1] = 32'h8000_F000; b_n[1] = 5'd12;
    b_op[2] = OP_SRL; b_x[2] = 32'hF0F0_F0F0; b_n[2] = 5'd28;
    b_op[3] = OP_ROL; b_x[3] = 32'hA5A5_A5A5; b_n[3] = 5'd31;
    b_op[4] = OP_ROR; b_x[4] = 32'h0000_FFFF; b_n[4] = 5'd16;
    b_op[5] = 3'd6;   b_x[5] = 32'hCAFE_0001; b_n[5] = 5'd9;
    b_op[6] = OP_SRL; b_x[6] = 32'h8765_4321; b_n[6] = 5'd0;
    b_op[7] = OP_ROR; b_x[7] = 32'h8000_0001; b_n[7] = 5'd31;
    prev_acc = 0;
    prev_k   = 0;
    for (int i = 0; i < 8; i++) begin
      issue("b2b", b_op[i], b_x[i], b_n[i]);
      if (i > 0) chk("b2b_spacing", acc_cyc - prev_acc, prev_k + 2);
      prev_acc = acc_cyc;
      prev_k   = passes(b_op[i], b_n[i]);
      wait_result("b2b", prev_k, ref_model(b_op[i], b_x[i], b_n[i]));
    end

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_exec_unit.md
Name: shift_exec_unit

Overview:
- Multi-cycle execute-stage shift/rotate unit for the decryption datapath.
- Accepts an operand, shift amount and opcode from decode over a valid/ready handshake.
- Sequences one combinational 32-bit barrel shifter over 1–3 passes and registers the result.
- Adds logical-right and rotate (left/right) operations, which the cipher rounds need, on top of the shifter's native left-logical and right-arithmetic shifts.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.
- SHAMT_W, 5, shift-amount width; fixed at log2(WIDTH).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept; high only in IDLE and only while reset_n=1.
- in_op  in  3  opcode: 0 SLL, 1 SRA, 2 SRL, 3 ROL, 4 ROR, 5–7 reserved.
- in_data  in  32  operand.
- in_shamt  in  5  shift amount n.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  32  result.

Behaviour:
- Reset (reset_n=0 at an edge):
  - state goes to IDLE; out_valid=0; out_data=0; internal registers cleared.
  - Applies from any state, including mid-pass or while holding a result; the in-flight operation is discarded.
- States: IDLE, PASS_A, PASS_B, PASS_C, DONE.
- Accept: in_valid & in_ready at an edge.
  - Latch op, data x and effective amount m; go to PASS_A.
  - For ROR, m = (32-n) mod 32 and the op is executed as ROL.
  - For all other ops, m = n.
- Zero amount or reserved op: the op is forced to SLL with m=0, so the result is x after one pass.
- Shifter sub-module ports: operand, amount, dir (0 = logical left, 1 = arithmetic right).
  - Exactly one instance, time-shared across passes through muxed inputs.
- One pass per cycle; each pass writes a 32-bit register.
- SLL: PASS_A computes x<<m and goes to DONE.
- SRA: PASS_A computes x>>>m and goes to DONE.
- SRL:
  - PASS_A: R = x>>>m.
  - PASS_B: S = 0xFFFFFFFF<<(32-m); result = R & ~S; go to DONE.
- ROL:
  - PASS_A: L = x<<m.
  - PASS_B: R = x>>>(32-m).
  - PASS_C: S = 0xFFFFFFFF<<m; result = L | (R & ~S); go to DONE.
- Amount arithmetic:
  - 32-m is computed in 6 bits and truncated to 5 bits.
  - It is only used when m is nonzero, so the value is always in 1..31.
- Latency: out_valid rises k cycles after the accept cycle, where k = number of passes.
  - SLL, SRA, zero amount, reserved op: k=1.
  - SRL: k=2.
  - ROL, ROR: k=3.
- DONE:
  - out_valid=1; out_data is stable until transfer.
  - Transfer on out_valid & out_ready; next state is IDLE.
  - With out_ready=0 the unit holds indefinitely; in_ready stays 0.
- No overlap: a new accept is possible only from the cycle after the transfer (IDLE).
  - Peak throughput is one op per k+2 cycles.
- in_valid during a non-IDLE state is ignored. Upstream must hold its request until it sees in_ready.
- Inputs are sampled only at the accept edge. Later changes to in_* have no effect on the in-flight op.
- out_data is 0 whenever out_valid=0 after reset. It is updated only on entry to DONE.

Decomposition:
- Shared package holds:
  - Opcode constants OP_SLL..OP_ROR.
  - State encoding constants.
  - ALL_ONES = 32'hFFFFFFFF.
  - Shifter direction constants DIR_LEFT=0 and DIR_ARITH_RIGHT=1.
- Sub-module: barrelshift, the existing combinational 32-bit shifter, instantiated once with no modification.
- This block contains only:
  - the FSM;
  - operand/amount/direction muxes;
  - the pass registers;
  - the final combine logic.

Test Plan:
- ROL x=0x80000001 n=1 -> out_data 0x00000003; out_valid rises 3 cycles after accept.
- SRL x=0x80000000 n=4 -> 0x08000000 in 2 cycles. SRA with the same inputs -> 0xF8000000 in 1 cycle. SRA n=31 -> 0xFFFFFFFF.
- ROR x=0x12345678 n=8 -> 0x78123456 in 3 cycles. ROR n=0 -> 0x12345678 in 1 cycle. Reserved op 7, n=5 -> 0x12345678 in 1 cycle.
- Backpressure: SLL x=0x1 n=4; hold out_ready=0 for 5 cycles.
  - out_valid=1 and out_data=0x00000010 held stable; in_ready=0.
  - A competing in_valid is ignored.
  - Raise out_ready -> transfer; in_ready=1 the next cycle.
- Reset mid-op: start ROL; drive reset_n=0 during PASS_B for one edge.
  - Next cycle: out_valid=0, out_data=0, state IDLE, in_ready=0 while reset_n=0.
  - Then SLL x=0x1 n=31 -> 0x80000000 with no trace of the aborted op.
- Back-to-back ops of mixed types with out_ready tied high:
  - Each result matches a reference model.
  - Spacing between accepts is exactly k+2 cycles.
